// File: rtl/mmio_uart_if.sv
// rtl/mmio_uart_if.sv - data-memory port bundle between the core and the UART target
interface mmio_uart_if;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        hit;

    modport master (output addr, output we, output wd, input rd, input hit);
    modport slave  (input addr, input we, input wd, output rd, output hit);
endinterface

// File: rtl/mmio_uart.sv
// rtl/mmio_uart.sv - memory-mapped 8N1 UART target with TX FIFO and RX holding register
module mmio_uart #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    mmio_uart_if.slave  bus,
    output logic        tx,
    input  logic        rx
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [DIV_W-1:0] BIT_END   = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] HALF_END  = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [DIV_W-1:0] CNT_ONE   = DIV_W'(1);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT1      = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_RXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;

    // Decode
    logic       hit;
    logic [1:0] reg_sel;
    logic       wr_tx;
    logic       wr_rx;
    logic       wr_status;

    // TX FIFO
    logic [7:0]       fifo_mem_q [FIFO_DEPTH];
    logic [7:0]       fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             drop;
    logic             pop;

    // TX FSM
    logic [1:0]       tx_state_q, tx_state_d;
    logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             tx_q, tx_d;
    logic             tx_busy;

    // RX synchronizer and FSM
    logic             rx_meta_q, rx_meta_d;
    logic             rx_sync_q, rx_sync_d;
    logic [1:0]       rx_state_q, rx_state_d;
    logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             rx_done_ok;
    logic             rx_done_bad;

    // Holding register and sticky status
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_ovr_q, rx_ovr_d;
    logic       frm_err_q, frm_err_d;
    logic       ovf_q, ovf_d;

    logic unused_bits;
    assign unused_bits = ^{bus.addr[1:0], bus.wd[31:8]};

    assign hit       = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign reg_sel   = bus.addr[3:2];
    assign wr_tx     = hit & bus.we & (reg_sel == REG_TXDATA);
    assign wr_rx     = hit & bus.we & (reg_sel == REG_RXDATA);
    assign wr_status = hit & bus.we & (reg_sel == REG_STATUS);
    assign bus.hit   = hit;

    assign fifo_full  = (count_q == FIFO_FULL);
    assign fifo_empty = (count_q == '0);
    // Full is judged on the pre-edge count, so a pop in the same cycle does not rescue the byte.
    assign push       = wr_tx & ~fifo_full;
    assign drop       = wr_tx & fifo_full;
    assign pop        = (tx_state_q == ST_IDLE) & ~fifo_empty;
    assign tx_busy    = (tx_state_q != ST_IDLE);
    assign tx         = tx_q;

    // Combinational register read; reads never change state
    always_comb begin
        bus.rd = '0;
        if (hit) begin
            case (reg_sel)
                REG_RXDATA: bus.rd = {rx_valid_q, 23'b0, rx_byte_q};
                REG_STATUS: bus.rd = {25'b0, frm_err_q, rx_ovr_q, ovf_q, rx_valid_q,
                                      tx_busy, fifo_empty, fifo_full};
                default:    bus.rd = '0;
            endcase
        end
    end

    // FIFO storage, pointers and occupancy
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = bus.wd[7:0];
            wr_ptr_d             = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT1;
            2'b01:   count_d = count_q - CNT1;
            default: count_d = count_q;
        endcase
    end

    // TX framing: start bit, 8 data bits LSB first, stop bit; tx registered from next state
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        case (tx_state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    tx_shift_d = fifo_mem_q[rd_ptr_q];
                    tx_cnt_d   = '0;
                    tx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = 3'd0;
                    tx_state_d = ST_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = ST_STOP;
                    end else begin
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_bit_d   = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d   = '0;
                    tx_state_d = ST_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
        case (tx_state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = tx_shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // RX: two-flop synchronizer, mid-bit sampling after a confirmed start bit
    always_comb begin
        rx_meta_d   = rx;
        rx_sync_d   = rx_meta_q;
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_done_ok  = 1'b0;
        rx_done_bad = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                if (!rx_sync_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (rx_cnt_q == HALF_END) begin
                    rx_cnt_d = '0;
                    if (rx_sync_q) begin
                        rx_state_d = ST_IDLE;
                    end else begin
                        rx_bit_d   = 3'd0;
                        rx_state_d = ST_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = ST_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d    = '0;
                    rx_state_d  = ST_IDLE;
                    rx_done_ok  = rx_sync_q;
                    rx_done_bad = ~rx_sync_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    // Holding register and sticky bits: hardware set takes priority over software clear
    always_comb begin
        rx_byte_d  = rx_byte_q;
        rx_valid_d = rx_valid_q;
        rx_ovr_d   = rx_ovr_q;
        frm_err_d  = frm_err_q;
        ovf_d      = ovf_q;
        if (wr_rx) begin
            rx_valid_d = 1'b0;
        end
        if (wr_status) begin
            if (bus.wd[4]) ovf_d     = 1'b0;
            if (bus.wd[5]) rx_ovr_d  = 1'b0;
            if (bus.wd[6]) frm_err_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
        if (rx_done_ok) begin
            rx_byte_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            // A clear arriving with the new byte consumes the old one, so no overrun then.
            if (rx_valid_q && !wr_rx) begin
                rx_ovr_d = 1'b1;
            end
        end
        if (rx_done_bad) begin
            frm_err_d = 1'b1;
        end
    end

    // State registers; reset aborts any frame and parks tx high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            frm_err_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            fifo_mem_q <= fifo_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            rx_meta_q  <= rx_meta_d;
            rx_sync_q  <= rx_sync_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
            frm_err_q  <= frm_err_d;
            ovf_q      <= ovf_d;
        end
    end
endmodule

// File: tb/tb_mmio_uart.sv
// tb/tb_mmio_uart.sv - randomized self-checking bench for mmio_uart
module tb_mmio_uart;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DIV   = 4;
    localparam int          DEPTH = 8;
    localparam logic [31:0] A_TX  = BASE;
    localparam logic [31:0] A_RX  = BASE + 32'h4;
    localparam logic [31:0] A_ST  = BASE + 32'h8;
    localparam logic [31:0] A_RSV = BASE + 32'hC;

    logic clk;
    logic rst_n;
    logic tx;
    logic rx;
    int   n_checks;
    int   n_errors;

    logic [7:0] exp_q[$];
    logic [7:0] mon_q[$];

    // reference state of the receive side
    logic       m_valid;
    logic [7:0] m_byte;
    logic       m_ovr;
    logic       m_frm;

    mmio_uart_if bus();

    mmio_uart #(
        .BASE_ADDR (BASE),
        .CLK_DIV   (DIV),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .tx   (tx),
        .rx   (rx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // decodes every frame seen on tx by sampling the middle of each bit
    initial begin : tx_monitor
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = tx;
                end
                repeat (DIV) @(negedge clk);
                mon_q.push_back(b);
            end
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.addr = a;
        bus.wd   = d;
        bus.we   = 1'b1;
        @(negedge clk);
        bus.we   = 1'b0;
        bus.addr = A_ST;
    endtask

    task automatic wait_tx_idle();
        int k;
        k = 0;
        bus.we   = 1'b0;
        bus.addr = A_ST;
        @(negedge clk);
        #1;
        while (bus.rd[2:0] != 3'b010 && k < 2000) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("tx_idle", {29'b0, bus.rd[2:0]}, 32'h2);
    endtask

    // n writes in consecutive cycles from idle: the first pops one cycle later,
    // so DEPTH+1 bytes fit and the rest are dropped
    task automatic tx_burst(input int n);
        logic [7:0]  b;
        logic [31:0] st;
        int          k;
        wait_tx_idle();
        exp_q.delete();
        mon_q.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            b        = 8'($urandom);
            bus.addr = A_TX | 32'($urandom_range(0, 3));
            bus.wd   = {24'($urandom), b};
            bus.we   = 1'b1;
            if (i < DEPTH + 1) exp_q.push_back(b);
        end
        @(negedge clk);
        bus.we   = 1'b0;
        bus.addr = A_ST;
        #1;
        st = {25'b0, 2'b00, (n > DEPTH + 1), 1'b0, (n >= 2), 1'b0, (n >= DEPTH + 1)};
        check("burst_status", bus.rd, st);
        k = 0;
        while (mon_q.size() < exp_q.size() && k < 1500) begin
            @(negedge clk);
            k++;
        end
        repeat (60) @(negedge clk);
        check("burst_count", mon_q.size(), exp_q.size());
        if (mon_q.size() == exp_q.size()) begin
            for (int i = 0; i < exp_q.size(); i++) begin
                check("burst_byte", {24'b0, mon_q[i]}, {24'b0, exp_q[i]});
            end
        end
        bus_write(A_ST, 32'h10 | 32'($urandom_range(0, 15)));
        #1;
        check("ovf_w1c", bus.rd, 32'h2);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (DIV) @(negedge clk);
        end
        rx = 1'b1;
        repeat (8) @(negedge clk);
        if (stop_bit) begin
            if (m_valid) m_ovr = 1'b1;
            m_valid = 1'b1;
            m_byte  = b;
        end else begin
            m_frm = 1'b1;
        end
    endtask

    task automatic rx_glitch();
        @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic rx_check(input string tag);
        @(negedge clk);
        bus.we   = 1'b0;
        bus.addr = A_RX | 32'($urandom_range(0, 3));
        #1;
        check({tag, "_rxdata"}, bus.rd, {m_valid, 23'b0, m_byte});
        bus.addr = A_ST;
        #1;
        check({tag, "_status"}, bus.rd, {25'b0, m_frm, m_ovr, 1'b0, m_valid, 3'b010});
    endtask

    initial begin : main
        logic        exp_tx;
        logic        exp_busy;
        logic [7:0]  a5;
        logic [31:0] d;
        int          idx;
        int          act;
        int          lows;

        n_checks = 0;
        n_errors = 0;
        m_valid  = 1'b0;
        m_byte   = 8'h00;
        m_ovr    = 1'b0;
        m_frm    = 1'b0;
        rst_n    = 1'b0;
        rx       = 1'b1;
        bus.addr = A_ST;
        bus.we   = 1'b0;
        bus.wd   = '0;

        // reset values and decode
        repeat (2) @(negedge clk);
        #1;
        check("rst_status", bus.rd, 32'h2);
        check("rst_tx", tx, 1);
        check("rst_hit", bus.hit, 1);
        bus.addr = BASE + 32'h10;
        #1;
        check("miss_hit", bus.hit, 0);
        check("miss_rd", bus.rd, 0);
        bus.addr = A_RSV;
        #1;
        check("rsv_rd", bus.rd, 0);
        bus.addr = A_TX;
        #1;
        check("txdata_rd", bus.rd, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        bus.addr = A_ST;
        repeat (3) @(negedge clk);
        #1;
        check("post_rst_status", bus.rd, 32'h2);

        // writes outside the window or to the reserved slot do nothing
        bus_write(BASE + 32'h10, 32'h0000_0055);
        bus_write(A_RSV, 32'hFFFF_FFFF);
        repeat (3) @(negedge clk);
        #1;
        check("ignored_writes", bus.rd, 32'h2);
        check("ignored_tx", tx, 1);

        // exact waveform of one frame
        a5 = 8'hA5;
        @(negedge clk);
        bus.addr = A_TX;
        bus.wd   = 32'h0000_00A5;
        bus.we   = 1'b1;
        @(negedge clk);
        bus.we   = 1'b0;
        bus.addr = A_ST;
        for (int n = 0; n <= 41; n++) begin
            #1;
            if (n >= 1 && n <= 10 * DIV) begin
                exp_busy = 1'b1;
                idx      = (n - 1) / DIV;
                if (idx == 0)      exp_tx = 1'b0;
                else if (idx == 9) exp_tx = 1'b1;
                else               exp_tx = a5[idx-1];
            end else begin
                exp_busy = 1'b0;
                exp_tx   = 1'b1;
            end
            check("a5_tx", tx, exp_tx);
            check("a5_busy", bus.rd[2], exp_busy);
            @(negedge clk);
        end

        // FIFO fill and overflow, then random burst lengths
        tx_burst(10);
        for (int r = 0; r < 3; r++) begin
            tx_burst($urandom_range(1, 10));
        end

        // receive path directed cases
        rx_frame(8'h3C, 1'b1);
        rx_check("rx_first");
        rx_frame(8'($urandom), 1'b1);
        rx_check("rx_overrun");
        bus_write(A_RX, 32'($urandom));
        m_valid = 1'b0;
        rx_check("rx_clear");
        rx_glitch();
        rx_check("rx_glitch");
        rx_frame(8'($urandom), 1'b0);
        rx_check("rx_frmerr");
        bus_write(A_ST, 32'h60);
        m_ovr = 1'b0;
        m_frm = 1'b0;
        rx_check("rx_w1c");

        // random receive traffic and register operations
        for (int r = 0; r < 14; r++) begin
            act = $urandom_range(0, 10);
            if (act <= 5) begin
                rx_frame(8'($urandom), 1'b1);
            end else if (act == 6) begin
                rx_frame(8'($urandom), 1'b0);
            end else if (act == 7) begin
                rx_glitch();
            end else if (act == 8) begin
                bus_write(A_RX | 32'($urandom_range(0, 3)), 32'($urandom));
                m_valid = 1'b0;
            end else if (act == 9) begin
                d = 32'($urandom);
                bus_write(A_ST, d);
                if (d[5]) m_ovr = 1'b0;
                if (d[6]) m_frm = 1'b0;
            end else begin
                bus_write(BASE + 32'h10 * 32'($urandom_range(1, 64)) + 32'h4, 32'hFFFF_FFFF);
            end
            rx_check("rx_rand");
        end

        // reset in the middle of a data bit
        bus_write(A_ST, 32'h70);
        bus_write(A_RX, 32'h0);
        wait_tx_idle();
        bus_write(A_TX, 32'h0000_0000);
        repeat (10) @(negedge clk);
        #1;
        check("pre_rst_tx", tx, 0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_tx", tx, 1);
        check("rst_mid_status", bus.rd, 32'h2);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lows  = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("post_rst_tx_low_cycles", lows, 0);
        #1;
        check("post_rst_status2", bus.rd, 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mmio_uart.md
Name: mmio_uart

Overview:
- Memory-mapped UART responder on the core's data-memory port (addr/we/wd/rd), decoded beside the RAM.
- The core is the bus initiator. This block is the target: single-cycle combinational read, write committed on the clock edge.
- Provides 8N1 serial TX through a FIFO and RX through a single holding register, plus status/sticky-error register. No read side effects; all pops and clears are by write.

Parameters:
- BASE_ADDR, 32'h1000_0000, 16-byte-aligned base of register window
- CLK_DIV, 16, clk cycles per serial bit (>=4, even)
- FIFO_DEPTH, 8, TX FIFO entries (power of two, >=2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- addr  in  32  byte address from core data port
- we  in  1  write strobe, sampled at posedge clk
- wd  in  32  write data
- rd  out  32  read data, combinational from addr
- hit  out  1  addr within window; top uses it to mux rd against RAM and gate RAM we
- tx  out  1  serial output, idle high
- rx  in  1  serial input, asynchronous

Behaviour:
- Decode
  - hit = (addr[31:4] == BASE_ADDR[31:4]); addr[1:0] ignored; addr[3:2] selects register.
  - When hit=0: rd=0 and writes are ignored.
- Registers
  - 0x0 TXDATA: write pushes wd[7:0] if FIFO not full at cycle start, else drops the byte and sets ovf. Read returns 0.
  - 0x4 RXDATA: read returns {rx_valid, 23'b0, rx_byte}. Any write clears rx_valid.
  - 0x8 STATUS: read returns {25'b0, frm_err, rx_ovr, ovf, rx_valid, tx_busy, tx_empty, tx_full}, bits 6..0. Write-1-to-clear for bits 4 (ovf), 5 (rx_ovr), 6 (frm_err); other bits read-only.
  - 0xC: reads 0, writes ignored.
- Reset (async)
  - tx=1, FIFO empty, both FSMs IDLE, rx_valid=0, rx_byte=0, all sticky bits 0.
  - rd/hit are combinational: rd=0 unless a register is addressed.
  - Reset mid-frame aborts the frame immediately; tx goes high.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE
  - IDLE, FIFO non-empty: at the edge, pop the head into the shift register and enter START. A byte written while in IDLE starts one cycle later.
  - START: tx=0 for CLK_DIV cycles.
  - DATA: 8 bits LSB first, CLK_DIV cycles each.
  - STOP: tx=1 for CLK_DIV cycles, then IDLE.
  - Back-to-back bytes: one idle cycle between frames (frame = 10*CLK_DIV+1 cycles including IDLE).
  - tx_busy=1 in any state other than IDLE.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Full check uses the pre-edge count: a write when count==FIFO_DEPTH is dropped even if a pop occurs that cycle.
  - Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
- RX FSM: IDLE -> START -> DATA -> STOP
  - rx passes through a 2-flop synchronizer before any use.
  - IDLE: wait for synchronized rx==0.
  - START: after CLK_DIV/2 cycles re-sample. If 1, false start: return to IDLE. If 0, continue.
  - DATA: sample every CLK_DIV cycles, 8 bits LSB first.
  - STOP: sample after a further CLK_DIV cycles.
    - Stop=1: load rx_byte and set rx_valid. If rx_valid was already 1, set rx_ovr and overwrite.
    - Stop=0: discard the byte and set frm_err.
    - Either way return to IDLE.
  - Completion and RXDATA write in the same cycle: completion wins; rx_valid=1, no overrun.
  - Sticky bit set by hardware and W1C in the same cycle: set wins.

Test Plan:
- Reset with rx=1, addr=BASE+8 -> rd=32'h2 (tx_empty); tx=1; hit=1; addr=BASE+16 -> hit=0, rd=0.
- CLK_DIV=4; write 8'hA5 to TXDATA -> tx low 4 cycles starting 1 cycle after write, then 1,0,1,0,0,1,0,1 (4 cycles each), then high; tx_busy=1 for 40 cycles.
- FIFO_DEPTH=8; write 10 bytes in consecutive cycles while IDLE -> 9 accepted (first pops after one cycle), 10th dropped, STATUS bit4=1; write 32'h10 to STATUS -> bit4=0.
- Drive rx frame 8'h3C at CLK_DIV=4 -> about 42 cycles later RXDATA reads 32'h8000_003C. Send a second frame without clearing -> rx_ovr=1, byte updated. Write RXDATA -> bit31=0.
- Drive rx low for 1 cycle only -> no rx_valid and no frm_err. Full frame with stop bit 0 -> frm_err=1, rx_valid unchanged.
- Assert rst_n=0 mid-TX data bit -> tx=1 immediately. After release STATUS=32'h2 and tx stays high.
